sample_writer: RTL and testbench

- Write-side address generator and loader for the sample memories (X/Y BRAMs) of the linear-regression datapath.
- Accepts a stream of samples over a valid/ready handshake and writes each one to consecutive memory addresses starting at a base address.
- Counts the samples, then signals completion so the read-side address counters can start sweeping the same memory.

---
 rtl/sample_writer_if.sv | 35 +++
 rtl/sample_writer.sv | 119 +++++++++++
 tb/tb_sample_writer.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_writer_if.sv
// Stream-in / memory-write bundle for sample_writer. The master modport is the
// upstream producer and memory side, the slave modport is the writer itself.
interface sample_writer_if #(
    parameter int DW = 32,
    parameter int AW = 8
);
    // A sample moves on a clk edge where in_valid & in_ready are both high.
    // in_valid must not depend on in_ready; in_data is only meaningful while
    // in_valid is high. mem_we/mem_addr/mem_wdata form a registered one-cycle
    // write strobe with no back-pressure from the memory.
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/sample_writer.sv
// Loads a stream of samples into consecutive X/Y sample-memory addresses and
// pulses done when finished. Define SAMPLE_WRITER_CHECKSUM_EN for a running sum.
module sample_writer #(
    parameter int DW = 32,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          CLR_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   num_samples,
    sample_writer_if.slave bus,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   loaded,
`ifdef SAMPLE_WRITER_CHECKSUM_EN
    output logic [DW-1:0] checksum,
`endif
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] addr_q;
    logic [AW:0]   remain_q;
    logic          hs;
    logic          start_ok;

    assign state_dbg = state_q;
    assign start_ok  = start && (state_q == IDLE);
    assign hs        = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (!CLR_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bus.in_ready = 1'b0;
        busy         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (num_samples == '0) ? FINISH : LOAD;
                end
            end
            LOAD: begin
                bus.in_ready = 1'b1;
                busy         = 1'b1;
                // The last handshake leaves LOAD so in_ready drops right after it.
                if (bus.in_valid && (remain_q == (AW+1)'(1))) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                busy    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!CLR_n) begin
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            addr_q        <= '0;
            remain_q      <= '0;
            loaded        <= '0;
            done          <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            done       <= (state_q == FINISH);
            if (start_ok) begin
                addr_q   <= base_addr;
                remain_q <= num_samples;
                loaded   <= '0;
            end
            // Address wraps naturally at 2^AW, so base+N past the top lands at 0.
            if (hs) begin
                bus.mem_we    <= 1'b1;
                bus.mem_addr  <= addr_q;
                bus.mem_wdata <= bus.in_data;
                addr_q        <= addr_q + AW'(1);
                remain_q      <= remain_q - (AW+1)'(1);
                loaded        <= loaded + (AW+1)'(1);
            end
        end
    end

`ifdef SAMPLE_WRITER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!CLR_n) begin
            checksum <= '0;
        end else if (start_ok) begin
            checksum <= '0;
        end else if (hs) begin
            checksum <= checksum + bus.in_data;
        end
    end
`endif

    a_done_not_busy : assert property (@(posedge clk) disable iff (!CLR_n)
        done |-> !busy);
    a_we_inside_txn : assert property (@(posedge clk) disable iff (!CLR_n)
        bus.mem_we |-> (state_q != IDLE));

endmodule

// File: tb/tb_sample_writer.sv
// Self-checking bench for sample_writer: randomized loads against a
// transaction-level model with a cycle-tagged write/done scoreboard.
module tb_sample_writer;
    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          CLR_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_samples;
    logic          busy;
    logic          done;
    logic [AW:0]   loaded;
    logic [1:0]    state_dbg;
`ifdef SAMPLE_WRITER_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    sample_writer_if #(.DW(DW), .AW(AW)) bus ();

    sample_writer #(.DW(DW), .AW(AW)) dut (
        .clk         (clk),
        .CLR_n       (CLR_n),
        .start       (start),
        .base_addr   (base_addr),
        .num_samples (num_samples),
        .bus         (bus.slave),
        .busy        (busy),
        .done        (done),
        .loaded      (loaded),
`ifdef SAMPLE_WRITER_CHECKSUM_EN
        .checksum    (checksum),
`endif
        .state_dbg   (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    logic [AW+DW-1:0] exp_q[$];
    int               exp_due_q[$];
    int               done_due_q[$];
    logic [DW-1:0]    data_src[$];
    logic [DW-1:0]    model_sum;

    // scoreboard: every write and done pulse must land on the cycle the model predicts
    always @(negedge clk) begin
        while (exp_due_q.size() > 0 && exp_due_q[0] < cyc) begin
            n_cmp++; n_err++;
            $display("FAIL write_missing: cycle %0d got no write, expected addr=%0h data=%0h",
                     exp_due_q[0], exp_q[0][AW+DW-1:DW], exp_q[0][DW-1:0]);
            void'(exp_q.pop_front()); void'(exp_due_q.pop_front());
        end
        if (bus.mem_we === 1'b1) begin
            n_cmp++;
            if (exp_due_q.size() == 0 || exp_due_q[0] != cyc) begin
                n_err++;
                $display("FAIL write_unexpected: cycle %0d got addr=%0h data=%0h, expected no write",
                         cyc, bus.mem_addr, bus.mem_wdata);
            end else begin
                if ({bus.mem_addr, bus.mem_wdata} !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL write_value: cycle %0d got addr=%0h data=%0h expected addr=%0h data=%0h",
                             cyc, bus.mem_addr, bus.mem_wdata, exp_q[0][AW+DW-1:DW], exp_q[0][DW-1:0]);
                end
                void'(exp_q.pop_front()); void'(exp_due_q.pop_front());
            end
        end else if (exp_due_q.size() > 0 && exp_due_q[0] == cyc) begin
            n_cmp++; n_err++;
            $display("FAIL write_missing: cycle %0d got mem_we=%b, expected addr=%0h data=%0h",
                     cyc, bus.mem_we, exp_q[0][AW+DW-1:DW], exp_q[0][DW-1:0]);
            void'(exp_q.pop_front()); void'(exp_due_q.pop_front());
        end

        if (done === 1'b1) begin
            n_cmp++;
            if (done_due_q.size() == 0 || done_due_q[0] != cyc) begin
                n_err++;
                $display("FAIL done_unexpected: cycle %0d got done=1, expected done=0", cyc);
            end else begin
                void'(done_due_q.pop_front());
            end
        end else if (done_due_q.size() > 0 && done_due_q[0] <= cyc) begin
            n_cmp++; n_err++;
            $display("FAIL done_missing: cycle %0d got done=%b expected 1", cyc, done);
            void'(done_due_q.pop_front());
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // driver: start a load in the current cycle, feed it, and return in the done cycle
    task automatic run_load(input logic [AW-1:0] base, input int n, input int mode,
                            input logic [31:0] pat, input bit poke);
        int            accepted = 0;
        int            k = 0;
        logic          v;
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        start       = 1'b1;
        base_addr   = base;
        num_samples = (AW+1)'(n);
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_data  = $urandom;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_err++; $display("FAIL idle_in_ready: got %b expected 0", bus.in_ready);
        end
        model_sum = '0;
        if (n == 0) done_due_q.push_back(cyc + 2);
        next_cycle();
        start = 1'b0;
        while (accepted < n && k < 4000) begin
            n_cmp++;
            if (bus.in_ready !== 1'b1 || busy !== 1'b1 || loaded !== (AW+1)'(accepted)) begin
                n_err++;
                $display("FAIL load_status: cycle %0d got in_ready=%b busy=%b loaded=%0d expected 1 1 %0d",
                         cyc, bus.in_ready, busy, loaded, accepted);
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = 1'($urandom_range(0, 1));
                default: v = (k < 32) ? pat[k] : 1'b1;
            endcase
            d = (data_src.size() > 0) ? data_src.pop_front() : $urandom;
            bus.in_valid = v;
            bus.in_data  = d;
            if (poke && k == 1) begin
                start = 1'b1; base_addr = ~base; num_samples = (AW+1)'(7);
            end else begin
                start = 1'b0;
            end
            if (v) begin
                a = base + AW'(accepted);
                exp_q.push_back({a, d});
                exp_due_q.push_back(cyc + 1);
                model_sum = model_sum + d;
                accepted++;
                if (accepted == n) done_due_q.push_back(cyc + 2);
            end
            k++;
            next_cycle();
        end
        if (accepted < n) begin
            n_cmp++; n_err++;
            $display("FAIL load_timeout: got %0d samples accepted expected %0d", accepted, n);
        end
        start = 1'b0;
        bus.in_valid = 1'($urandom_range(0, 1));
        n_cmp++;
        if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL finish_status: cycle %0d got in_ready=%b busy=%b expected 0 1",
                     cyc, bus.in_ready, busy);
        end
        next_cycle();
        bus.in_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || bus.in_ready !== 1'b0 || loaded !== (AW+1)'(n)) begin
            n_err++;
            $display("FAIL done_status: cycle %0d got busy=%b in_ready=%b loaded=%0d expected 0 0 %0d",
                     cyc, busy, bus.in_ready, loaded, n);
        end
`ifdef SAMPLE_WRITER_CHECKSUM_EN
        n_cmp++;
        if (checksum !== model_sum) begin
            n_err++; $display("FAIL checksum: got %0h expected %0h", checksum, model_sum);
        end
`endif
    endtask

    task automatic test_reset();
        CLR_n = 1'b0; start = 1'b1; base_addr = 8'hAA; num_samples = 9'd5;
        bus.in_valid = 1'b1; bus.in_data = $urandom;
        repeat (3) next_cycle();
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: got in_ready=%b mem_we=%b busy=%b done=%b expected all 0",
                     bus.in_ready, bus.mem_we, busy, done);
        end
        n_cmp++;
        if (bus.mem_addr !== '0 || bus.mem_wdata !== '0 || loaded !== '0) begin
            n_err++;
            $display("FAIL reset_values: got addr=%0h wdata=%0h loaded=%0d expected 0 0 0",
                     bus.mem_addr, bus.mem_wdata, loaded);
        end
`ifdef SAMPLE_WRITER_CHECKSUM_EN
        n_cmp++;
        if (checksum !== '0) begin
            n_err++; $display("FAIL reset_checksum: got %0h expected 0", checksum);
        end
`endif
        CLR_n = 1'b1; start = 1'b0; bus.in_valid = 1'b0;
        next_cycle();
    endtask

    task automatic test_basic();
        data_src = '{32'd1, 32'd2, 32'd3, 32'd4};
        run_load(8'h10, 4, 0, 32'h0, 1'b0);
        next_cycle();
    endtask

    task automatic test_backpressure();
        run_load(8'h30, 3, 2, 32'b101001, 1'b0);
        next_cycle();
    endtask

    task automatic test_wrap_full();
        run_load(8'hFE, 4, 1, 32'h0, 1'b0);
        run_load(8'h00, DEPTH, 0, 32'h0, 1'b0);
        next_cycle();
    endtask

    task automatic test_zero_length();
        run_load(8'h55, 0, 0, 32'h0, 1'b0);
        run_load(8'h56, 0, 0, 32'h0, 1'b0);
        run_load(8'h57, 2, 0, 32'h0, 1'b0);
        next_cycle();
    endtask

    task automatic test_reset_mid_load();
        start = 1'b1; base_addr = 8'h40; num_samples = 9'd5; bus.in_valid = 1'b0;
        next_cycle();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = $urandom;
            exp_q.push_back({8'h40 + 8'(i), bus.in_data});
            exp_due_q.push_back(cyc + 1);
            next_cycle();
        end
        CLR_n = 1'b0; bus.in_valid = 1'b1; bus.in_data = $urandom;
        next_cycle();
        n_cmp++;
        if (bus.mem_we !== 1'b0 || bus.in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            bus.mem_addr !== '0 || bus.mem_wdata !== '0 || loaded !== '0) begin
            n_err++;
            $display("FAIL midload_reset: got we=%b rdy=%b busy=%b done=%b addr=%0h wdata=%0h loaded=%0d expected all 0",
                     bus.mem_we, bus.in_ready, busy, done, bus.mem_addr, bus.mem_wdata, loaded);
        end
        CLR_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_data = $urandom;
            next_cycle();
            n_cmp++;
            if (bus.in_ready !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL after_reset_idle: got in_ready=%b busy=%b expected 0 0",
                         bus.in_ready, busy);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            run_load(8'($urandom), $urandom_range(0, 20), 1, 32'h0, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) next_cycle();
        end
        next_cycle();
    endtask

    task automatic test_checksum();
`ifdef SAMPLE_WRITER_CHECKSUM_EN
        data_src = '{32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0003};
        run_load(8'h20, 3, 0, 32'h0, 1'b0);
        n_cmp++;
        if (checksum !== 32'h0000_0004) begin
            n_err++; $display("FAIL checksum_wrap: got %0h expected 4", checksum);
        end
        next_cycle();
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap_full();
        test_zero_length();
        test_reset_mid_load();
        test_back_to_back();
        test_checksum();
        repeat (3) next_cycle();
        n_cmp++;
        if (exp_q.size() != 0 || done_due_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover_expect: got %0d writes %0d dones pending expected 0 0",
                     exp_q.size(), done_due_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
